// File: rtl/pll_supervisor_pkg.sv
// -----------------------------------------------------------------------------
// pll_supervisor_pkg
//
// Shared definitions for the PLL lock/reset supervisor.
//   SUP_STATE_W    : width of the exported FSM state (3 bits)
//   sup_state_e    : FSM state encoding, also visible on the debug 'state' port
//                    RESET_PLL=0, WAIT_LOCK=1, QUALIFY=2, RELEASE=3, RUN=4
//   sup_cnt_width  : width of the shared timing counter, derived from the
//                    largest interval it ever has to measure
// -----------------------------------------------------------------------------
package pll_supervisor_pkg;

    localparam int SUP_STATE_W = 3;

    typedef enum logic [SUP_STATE_W-1:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        QUALIFY   = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } sup_state_e;

    // The shared counter only ever has to reach (interval - 1), so
    // $clog2 of the longest interval is enough. A width of at least one bit
    // is kept so that degenerate all-ones parameter sets still elaborate.
    function automatic int unsigned sup_cnt_width(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c,
        input int unsigned d
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m < 2) sup_cnt_width = 1;
        else       sup_cnt_width = $clog2(m);
    endfunction

endpackage

// File: rtl/pll_supervisor_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// Generic two-flop synchroniser for bringing asynchronous level signals into
// the clk_i domain. Both stages reset to 0 so that a freshly reset design
// always sees the input as deasserted for the first two cycles.
//
// Ports:
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset
//   d_i     : asynchronous input bus (WIDTH bits, each bit independent)
//   q_o     : synchronised output, two clk_i cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First stage may go metastable; the second stage gives it a full cycle
    // to resolve before anything downstream looks at the value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// -----------------------------------------------------------------------------
// pll_supervisor
//
// Sequencer for the PLL lock and reset path, clocked by the free-running
// reference clock. Instead of using the raw PLL LOCK pin as a reset, it:
//   - holds the PLL in reset (RESETB low) for RESET_CYCLES per attempt,
//   - waits up to LOCK_TIMEOUT cycles for lock and retries on timeout,
//   - qualifies lock over STABLE_CYCLES consecutive cycles,
//   - releases NUM_DOMAINS resets one after the other, STAGGER_CYCLES apart,
//   - re-runs the whole sequence whenever lock is lost after qualification.
//
// Ports:
//   clock         : reference clock, the only clock of the block
//   reset_n       : asynchronous active-low reset
//   pll_locked    : raw PLL LOCK, asynchronous to clock
//   pll_resetb    : PLL RESETB, low holds the PLL in reset
//   domain_rst_n  : per-domain active-low resets, bit 0 released first
//   ready         : high only while in RUN
//   state         : current FSM state (debug)
//   retry_count   : saturating count of lock timeouts
//   loss_count    : saturating count of lock losses in RELEASE/RUN
//
// Configuration macro:
//   PLL_SUPERVISOR_STATS_EN : when defined, retry_count/loss_count are real
//                             saturating counters; otherwise both ports are
//                             tied to 0 and the counters do not exist.
//
// Every output is driven straight from a flop; there is no combinational
// path from pll_locked or reset release to any output.
// -----------------------------------------------------------------------------
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int NUM_DOMAINS    = 2,
    parameter int RESET_CYCLES   = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   pll_locked,
    output logic                   pll_resetb,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   ready,
    output logic [SUP_STATE_W-1:0] state,
    output logic [CNT_W-1:0]       retry_count,
    output logic [CNT_W-1:0]       loss_count
);

    localparam int unsigned CNT_BITS = sup_cnt_width(RESET_CYCLES, LOCK_TIMEOUT,
                                                     STABLE_CYCLES,
                                                     STAGGER_CYCLES * NUM_DOMAINS);
    localparam int unsigned CW1 = CNT_BITS + 1;

    localparam logic [CNT_BITS-1:0] RESET_LAST   = CNT_BITS'(RESET_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] TIMEOUT_LAST = CNT_BITS'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_BITS-1:0] STABLE_LAST  = CNT_BITS'(STABLE_CYCLES - 1);
    localparam logic [CW1-1:0]      RELEASE_END  = CW1'(STAGGER_CYCLES * NUM_DOMAINS);

    logic                   lock_s;

    sup_state_e             state_q;
    logic [CNT_BITS-1:0]    cnt_q;
    logic                   pll_resetb_q;
    logic                   ready_q;
    logic [NUM_DOMAINS-1:0] domain_q;

    logic [CW1-1:0]         cnt_inc_d;
    logic                   reset_done_d;
    logic                   timeout_d;
    logic                   stable_done_d;
    logic                   release_done_d;
    logic                   loss_d;
    logic [NUM_DOMAINS-1:0] release_mask_d;

    // Raw LOCK is asynchronous, so it only enters the FSM through a
    // two-flop synchroniser. This accounts for two of the three cycles
    // between a LOCK edge and the FSM reacting to it.
    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .d_i    (pll_locked),
        .q_o    (lock_s)
    );

    // Decode of the shared counter. cnt_inc_d is one bit wider than cnt_q
    // so that the final release point (STAGGER_CYCLES * NUM_DOMAINS) can be
    // compared even when it equals 2**CNT_BITS. In RELEASE, a domain bit is
    // flagged on the edge where the elapsed cycle count reaches its slot,
    // i.e. STAGGER_CYCLES*(i+1) edges after RELEASE was entered. A timeout
    // only counts when lock is absent, which lets lock win a tie.
    always_comb begin
        cnt_inc_d      = {1'b0, cnt_q} + CW1'(1);
        reset_done_d   = (cnt_q == RESET_LAST);
        stable_done_d  = (cnt_q == STABLE_LAST);
        release_done_d = (cnt_inc_d == RELEASE_END);
        timeout_d      = (state_q == WAIT_LOCK) && !lock_s && (cnt_q == TIMEOUT_LAST);
        loss_d         = ((state_q == RELEASE) || (state_q == RUN)) && !lock_s;
        release_mask_d = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (cnt_inc_d == CW1'(STAGGER_CYCLES * (i + 1))) begin
                release_mask_d[i] = 1'b1;
            end
        end
    end

    // Main sequencer. All outputs are registered here alongside the state so
    // they change on the same edge as the transition that implies them:
    // pll_resetb rises on the edge that enters WAIT_LOCK and falls on the
    // edge that enters RESET_PLL, and ready rises together with the last
    // domain release. Domain bits are only ever OR-ed in during RELEASE, so
    // the release order stays monotonic; they all drop together on a loss.
    // Loss of lock during QUALIFY is not a loss event: it simply falls back
    // to WAIT_LOCK with a fresh timeout window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RESET_PLL;
            cnt_q        <= '0;
            pll_resetb_q <= 1'b0;
            ready_q      <= 1'b0;
            domain_q     <= '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (reset_done_d) begin
                        state_q      <= WAIT_LOCK;
                        cnt_q        <= '0;
                        pll_resetb_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_d[CNT_BITS-1:0];
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q <= QUALIFY;
                        cnt_q   <= '0;
                    end else if (timeout_d) begin
                        state_q      <= RESET_PLL;
                        cnt_q        <= '0;
                        pll_resetb_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc_d[CNT_BITS-1:0];
                    end
                end
                QUALIFY: begin
                    if (!lock_s) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (stable_done_d) begin
                        state_q <= RELEASE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc_d[CNT_BITS-1:0];
                    end
                end
                RELEASE: begin
                    if (loss_d) begin
                        state_q      <= RESET_PLL;
                        cnt_q        <= '0;
                        pll_resetb_q <= 1'b0;
                        ready_q      <= 1'b0;
                        domain_q     <= '0;
                    end else begin
                        domain_q <= domain_q | release_mask_d;
                        if (release_done_d) begin
                            state_q <= RUN;
                            cnt_q   <= '0;
                            ready_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc_d[CNT_BITS-1:0];
                        end
                    end
                end
                RUN: begin
                    if (loss_d) begin
                        state_q      <= RESET_PLL;
                        cnt_q        <= '0;
                        pll_resetb_q <= 1'b0;
                        ready_q      <= 1'b0;
                        domain_q     <= '0;
                    end
                end
                default: begin
                    state_q      <= RESET_PLL;
                    cnt_q        <= '0;
                    pll_resetb_q <= 1'b0;
                    ready_q      <= 1'b0;
                    domain_q     <= '0;
                end
            endcase
        end
    end

`ifdef PLL_SUPERVISOR_STATS_EN
    logic [CNT_W-1:0] retry_q;
    logic [CNT_W-1:0] loss_q;

    // Event counters for field diagnostics. They stick at all-ones rather
    // than wrapping so a large value can never be mistaken for a small one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            if (timeout_d && (retry_q != '1)) begin
                retry_q <= retry_q + CNT_W'(1);
            end
            if (loss_d && (loss_q != '1)) begin
                loss_q <= loss_q + CNT_W'(1);
            end
        end
    end

    assign retry_count = retry_q;
    assign loss_count  = loss_q;
`else
    // Statistics are compiled out; the ports stay so integrations do not
    // change shape, but they read as constant zero.
    assign retry_count = '0;
    assign loss_count  = '0;
`endif

    assign pll_resetb   = pll_resetb_q;
    assign domain_rst_n = domain_q;
    assign ready        = ready_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_supervisor
//
// Self-checking bench for pll_supervisor. A reference model tracks the
// supervisor as "phase plus cycles elapsed in that phase" and derives all
// outputs from that; directed scenarios additionally check the key latencies
// against fixed cycle numbers. A second instance with 2-bit counters covers
// saturation. Honours PLL_SUPERVISOR_STATS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_pll_supervisor;

    localparam int ND     = 3;
    localparam int RC     = 4;
    localparam int LT     = 32;
    localparam int SC     = 8;
    localparam int STG    = 2;
    localparam int CW     = 8;
    localparam int CWS    = 2;
    localparam int PERIOD = RC + LT;
    localparam int MAXC   = 255;

    localparam int P_RESET = 0;
    localparam int P_WAIT  = 1;
    localparam int P_QUAL  = 2;
    localparam int P_REL   = 3;
    localparam int P_RUN   = 4;

`ifdef PLL_SUPERVISOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           clock       = 1'b0;
    logic           reset_n     = 1'b0;
    logic           pll_locked  = 1'b0;
    logic           pll_resetb;
    logic [ND-1:0]  domain_rst_n;
    logic           ready;
    logic [2:0]     state;
    logic [CW-1:0]  retry_count;
    logic [CW-1:0]  loss_count;

    logic           reset_n_sat    = 1'b0;
    logic           pll_locked_sat = 1'b0;
    logic           pll_resetb_sat;
    logic [ND-1:0]  domain_rst_n_sat;
    logic           ready_sat;
    logic [2:0]     state_sat;
    logic [CWS-1:0] retry_count_sat;
    logic [CWS-1:0] loss_count_sat;

    int checks = 0;
    int errors = 0;

    int m_phase = 0;
    int m_age   = 0;
    int m_retry = 0;
    int m_loss  = 0;
    bit m_s1    = 1'b0;
    bit m_s2    = 1'b0;

    logic [23:0] obs;

    always #5 clock = ~clock;

    pll_supervisor #(
        .NUM_DOMAINS    (ND),
        .RESET_CYCLES   (RC),
        .LOCK_TIMEOUT   (LT),
        .STABLE_CYCLES  (SC),
        .STAGGER_CYCLES (STG),
        .CNT_W          (CW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .pll_resetb   (pll_resetb),
        .domain_rst_n (domain_rst_n),
        .ready        (ready),
        .state        (state),
        .retry_count  (retry_count),
        .loss_count   (loss_count)
    );

    pll_supervisor #(
        .NUM_DOMAINS    (ND),
        .RESET_CYCLES   (RC),
        .LOCK_TIMEOUT   (LT),
        .STABLE_CYCLES  (SC),
        .STAGGER_CYCLES (STG),
        .CNT_W          (CWS)
    ) dut_sat (
        .clock        (clock),
        .reset_n      (reset_n_sat),
        .pll_locked   (pll_locked_sat),
        .pll_resetb   (pll_resetb_sat),
        .domain_rst_n (domain_rst_n_sat),
        .ready        (ready_sat),
        .state        (state_sat),
        .retry_count  (retry_count_sat),
        .loss_count   (loss_count_sat)
    );

    assign obs = {state, pll_resetb, domain_rst_n, ready, retry_count, loss_count};

    // Reference model: a phase and the number of edges spent in it. The
    // synchronised lock is the raw lock delayed by two edges. Outputs are
    // computed from the phase and elapsed time in expected_vec().
    initial begin : ref_model
        bit ls;
        int el;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_phase = P_RESET;
                m_age   = 0;
                m_retry = 0;
                m_loss  = 0;
                m_s1    = 1'b0;
                m_s2    = 1'b0;
            end else begin
                ls    = m_s2;
                m_s2  = m_s1;
                m_s1  = pll_locked;
                el    = m_age + 1;
                m_age = el;
                case (m_phase)
                    P_RESET: begin
                        if (el == RC) begin m_phase = P_WAIT; m_age = 0; end
                    end
                    P_WAIT: begin
                        if (ls) begin
                            m_phase = P_QUAL; m_age = 0;
                        end else if (el == LT) begin
                            m_phase = P_RESET; m_age = 0;
                            if (m_retry < MAXC) m_retry = m_retry + 1;
                        end
                    end
                    P_QUAL: begin
                        if (!ls) begin
                            m_phase = P_WAIT; m_age = 0;
                        end else if (el == SC) begin
                            m_phase = P_REL; m_age = 0;
                        end
                    end
                    default: begin
                        if (!ls) begin
                            m_phase = P_RESET; m_age = 0;
                            if (m_loss < MAXC) m_loss = m_loss + 1;
                        end else if (m_phase == P_REL && el == STG * ND) begin
                            m_phase = P_RUN; m_age = 0;
                        end
                    end
                endcase
            end
        end
    end

    function automatic logic [23:0] expected_vec();
        logic [ND-1:0] d;
        d = '0;
        if (m_phase == P_RUN) begin
            d = '1;
        end else if (m_phase == P_REL) begin
            for (int i = 0; i < ND; i++) begin
                if (m_age >= STG * (i + 1)) d[i] = 1'b1;
            end
        end
        return {3'(m_phase), (m_phase != P_RESET), d, (m_phase == P_RUN),
                (STATS ? 8'(m_retry) : 8'h00), (STATS ? 8'(m_loss) : 8'h00)};
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        pll_locked = 1'b1;
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_values got=%h want=%h", obs, 24'h0);
        end
        checks++;
        if (obs !== expected_vec()) begin
            errors++;
            $display("[TB] FAIL reset_model got=%h want=%h", obs, expected_vec());
        end
        pll_locked = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_nominal();
        logic [ND-1:0] wantDom;
        pll_locked = 1'b0;
        apply_reset();
        for (int n = 0; n < 20 && pll_resetb !== 1'b1; n++) begin
            @(negedge clock);
            checks++;
            if (obs !== expected_vec()) begin
                errors++;
                $display("[TB] FAIL nominal_model got=%h want=%h", obs, expected_vec());
            end
        end
        checks++;
        if (pll_resetb !== 1'b1) begin
            errors++;
            $display("[TB] FAIL nominal_resetb_rise got=%b want=1", pll_resetb);
        end
        repeat (9) @(negedge clock);
        pll_locked = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clock);
            checks++;
            if (obs !== expected_vec()) begin
                errors++;
                $display("[TB] FAIL nominal_model e=%0d got=%h want=%h", e, obs, expected_vec());
            end
            if (e == 2 || e == 3) begin
                checks++;
                if (state !== 3'(e - 1)) begin
                    errors++;
                    $display("[TB] FAIL nominal_qualify_entry e=%0d got=%0d want=%0d", e, state, e - 1);
                end
            end
            if (e >= 12 && e <= 17) begin
                wantDom = (e >= 17) ? 3'b111 : (e >= 15) ? 3'b011 : (e >= 13) ? 3'b001 : 3'b000;
                checks++;
                if ({domain_rst_n, ready} !== {wantDom, (e >= 17)}) begin
                    errors++;
                    $display("[TB] FAIL nominal_stagger e=%0d got=%b/%b want=%b/%b",
                             e, domain_rst_n, ready, wantDom, (e >= 17));
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic wantRb;
        int   wantRt;
        pll_locked = 1'b0;
        apply_reset();
        for (int n = 1; n <= 3 * PERIOD + 5; n++) begin
            @(negedge clock);
            wantRb = ((n % PERIOD) >= RC);
            wantRt = STATS ? (n / PERIOD) : 0;
            checks++;
            if (pll_resetb !== wantRb || retry_count !== 8'(wantRt)) begin
                errors++;
                $display("[TB] FAIL timeout_retry n=%0d got=%b/%0d want=%b/%0d",
                         n, pll_resetb, retry_count, wantRb, wantRt);
            end
            checks++;
            if (obs !== expected_vec()) begin
                errors++;
                $display("[TB] FAIL timeout_model n=%0d got=%h want=%h", n, obs, expected_vec());
            end
        end
    endtask

    task automatic test_lock_at_timeout();
        pll_locked = 1'b0;
        apply_reset();
        repeat (33) @(negedge clock);
        pll_locked = 1'b1;
        for (int n = 34; n <= 36; n++) begin
            @(negedge clock);
            checks++;
            if (obs !== expected_vec()) begin
                errors++;
                $display("[TB] FAIL tie_model n=%0d got=%h want=%h", n, obs, expected_vec());
            end
        end
        checks++;
        if (state !== 3'd2 || retry_count !== 8'h00 || pll_resetb !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tie_lock_wins got=%0d/%0d/%b want=2/0/1", state, retry_count, pll_resetb);
        end
    endtask

    task automatic test_glitch();
        int j;
        bit seenWait;
        pll_locked = 1'b0;
        apply_reset();
        for (int n = 0; n < 20 && pll_resetb !== 1'b1; n++) @(negedge clock);
        pll_locked = 1'b1;
        for (int n = 0; n < 10 && state !== 3'd2; n++) begin
            @(negedge clock);
            checks++;
            if (obs !== expected_vec()) begin
                errors++;
                $display("[TB] FAIL glitch_model got=%h want=%h", obs, expected_vec());
            end
        end
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("[TB] FAIL glitch_reach_qualify got=%0d want=2", state);
        end
        j = $urandom_range(0, 4);
        repeat (j) @(negedge clock);
        pll_locked = 1'b0;
        @(negedge clock);
        pll_locked = 1'b1;
        seenWait = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clock);
            if (state === 3'd1) seenWait = 1'b1;
            checks++;
            if (obs !== expected_vec()) begin
                errors++;
                $display("[TB] FAIL glitch_model e=%0d got=%h want=%h", e, obs, expected_vec());
            end
            if (e == 16 || e == 17) begin
                checks++;
                if (ready !== (e == 17) || loss_count !== 8'h00) begin
                    errors++;
                    $display("[TB] FAIL glitch_fresh_window e=%0d got=%b/%0d want=%b/0",
                             e, ready, loss_count, (e == 17));
                end
            end
        end
        checks++;
        if (!seenWait) begin
            errors++;
            $display("[TB] FAIL glitch_back_to_wait got=%b want=1", seenWait);
        end
    endtask

    task automatic test_run_loss();
        pll_locked = 1'b0;
        apply_reset();
        for (int n = 0; n < 20 && pll_resetb !== 1'b1; n++) @(negedge clock);
        repeat ($urandom_range(0, 5)) @(negedge clock);
        pll_locked = 1'b1;
        for (int n = 0; n < 40 && state !== 3'd4; n++) begin
            @(negedge clock);
            checks++;
            if (obs !== expected_vec()) begin
                errors++;
                $display("[TB] FAIL loss_model got=%h want=%h", obs, expected_vec());
            end
        end
        checks++;
        if (state !== 3'd4) begin
            errors++;
            $display("[TB] FAIL loss_reach_run got=%0d want=4", state);
        end
        repeat ($urandom_range(1, 10)) @(negedge clock);
        pll_locked = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clock);
            checks++;
            if (obs !== expected_vec()) begin
                errors++;
                $display("[TB] FAIL loss_model e=%0d got=%h want=%h", e, obs, expected_vec());
            end
            if (e == 2) begin
                checks++;
                if (domain_rst_n !== 3'b111 || ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL loss_too_early got=%b/%b want=111/1", domain_rst_n, ready);
                end
            end
            if (e == 3) begin
                checks++;
                if (domain_rst_n !== 3'b000 || ready !== 1'b0 || loss_count !== (STATS ? 8'h01 : 8'h00)) begin
                    errors++;
                    $display("[TB] FAIL loss_teardown got=%b/%b/%0d want=000/0/%0d",
                             domain_rst_n, ready, loss_count, STATS ? 1 : 0);
                end
            end
            if (e >= 3 && e <= 7) begin
                checks++;
                if (pll_resetb !== (e == 7)) begin
                    errors++;
                    $display("[TB] FAIL loss_pll_reset e=%0d got=%b want=%b", e, pll_resetb, (e == 7));
                end
            end
        end
    endtask

    task automatic test_reset_mid_release();
        pll_locked = 1'b1;
        for (int n = 0; n < 40 && domain_rst_n !== 3'b001; n++) begin
            @(negedge clock);
            checks++;
            if (obs !== expected_vec()) begin
                errors++;
                $display("[TB] FAIL midrel_model got=%h want=%h", obs, expected_vec());
            end
        end
        checks++;
        if (domain_rst_n !== 3'b001 || loss_count !== (STATS ? 8'h01 : 8'h00)) begin
            errors++;
            $display("[TB] FAIL midrel_reach got=%b/%0d want=001/%0d", domain_rst_n, loss_count, STATS ? 1 : 0);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 24'h0) begin
            errors++;
            $display("[TB] FAIL midrel_async_reset got=%h want=%h", obs, 24'h0);
        end
        @(negedge clock);
        checks++;
        if (obs !== expected_vec()) begin
            errors++;
            $display("[TB] FAIL midrel_hold got=%h want=%h", obs, expected_vec());
        end
        pll_locked = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_saturation();
        int k;
        int want;
        logic wantRb;
        pll_locked_sat = 1'b0;
        @(negedge clock);
        reset_n_sat = 1'b0;
        repeat (2) @(negedge clock);
        reset_n_sat = 1'b1;
        for (int n = 1; n <= 5 * PERIOD + 1; n++) begin
            @(negedge clock);
            wantRb = ((n % PERIOD) >= RC);
            checks++;
            if ({state_sat, pll_resetb_sat, domain_rst_n_sat, ready_sat} !== {3'(wantRb), wantRb, 3'b000, 1'b0}) begin
                errors++;
                $display("[TB] FAIL sat_outputs n=%0d got=%0d/%b/%b/%b want=%0d/%b/000/0",
                         n, state_sat, pll_resetb_sat, domain_rst_n_sat, ready_sat, wantRb, wantRb);
            end
            if ((n % PERIOD) == 1) begin
                k    = n / PERIOD;
                want = STATS ? ((k > 3) ? 3 : k) : 0;
                checks++;
                if (retry_count_sat !== 2'(want) || loss_count_sat !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL sat_retry k=%0d got=%0d/%0d want=%0d/0",
                             k, retry_count_sat, loss_count_sat, want);
                end
            end
        end
    endtask

    task automatic test_random();
        int remain;
        remain = 0;
        pll_locked = 1'b0;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            if (remain <= 0) begin
                if (pll_locked) begin
                    pll_locked = 1'b0;
                    remain = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 45))
                                                         : int'($urandom_range(1, 4));
                end else begin
                    pll_locked = 1'b1;
                    remain = int'($urandom_range(1, 40));
                end
            end
            remain--;
            @(negedge clock);
            checks++;
            if (obs !== expected_vec()) begin
                errors++;
                $display("[TB] FAIL random_model c=%0d got=%h want=%h", c, obs, expected_vec());
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired got=running want=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] starting, stats=%0d", STATS);
        test_reset();
        test_nominal();
        test_timeout();
        test_lock_at_timeout();
        test_glitch();
        test_run_loss();
        test_reset_mid_release();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
